seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, n iterations per operation.
// A zero divisor skips iteration and returns an all-ones quotient with the dividend as remainder.
module seq_divider #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         ack,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic {
    IDLE,
    COMPUTE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [n-1:0]   q_reg;
  logic [n-1:0]   d_reg;
  logic [n:0]     r_reg;
  logic [CW-1:0]  cnt;
  logic           dbz_reg;
  logic           start;
  logic           step;
  logic [n+1:0]   r_wide;
  logic [n+1:0]   trial;
  logic           borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ack is decoded purely from the state register and the counter
  always_comb begin
    state_next = state;
    start      = 1'b0;
    step       = 1'b0;
    ack        = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          start      = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (cnt == '0) begin
          ack        = 1'b1;
          state_next = IDLE;
        end else if (!dbz_reg) begin
          step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // {R,Q} shifted left by one, with the trial subtraction one bit wider to expose the borrow
  always_comb begin
    r_wide = {r_reg, q_reg[n-1]};
    trial  = r_wide - {2'b00, d_reg};
    borrow = trial[n+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      cnt     <= '0;
      dbz_reg <= 1'b0;
    end else if (start) begin
      d_reg   <= divisor;
      dbz_reg <= (divisor == '0);
      if (divisor == '0) begin
        q_reg <= '1;
        r_reg <= {1'b0, dividend};
        cnt   <= '0;
      end else begin
        q_reg <= dividend;
        r_reg <= '0;
        cnt   <= CW'(n);
      end
    end else if (step) begin
      r_reg <= borrow ? r_wide[n:0] : trial[n:0];
      q_reg <= {q_reg[n-2:0], ~borrow};
      cnt   <= cnt - CW'(1);
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg[n-1:0];
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against an arithmetic reference (integer / and %).
module tb_seq_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         ack;
  logic         busy;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.n(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .ack        (ack),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int refQuot(input int dd, input int dv);
    return (dv == 0) ? (1 << N) - 1 : dd / dv;
  endfunction

  function automatic int refRem(input int dd, input int dv);
    return (dv == 0) ? dd : dd % dv;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents operands with req for exactly one accepting edge; returns #1 after that edge
  task automatic applyStimulus(input int dd, input int dv);
    @(negedge clk);
    dividend = N'(dd);
    divisor  = N'(dv);
    req      = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic waitAck(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ack && cycles < 40);
  endtask

  task automatic runOp(input string tag, input int dd, input int dv);
    int cyc;
    applyStimulus(dd, dv);
    waitAck(cyc);
    checkOutput({tag, " latency"}, cyc, (dv == 0) ? 1 : N + 1);
    checkOutput({tag, " quotient"}, int'(quotient), refQuot(dd, dv));
    checkOutput({tag, " remainder"}, int'(remainder), refRem(dd, dv));
    checkOutput({tag, " dbz"}, int'(div_by_zero), (dv == 0) ? 1 : 0);
    if (dv != 0)
      checkOutput({tag, " identity"}, int'(quotient) * dv + int'(remainder), dd);
    @(negedge clk);
    checkOutput({tag, " ack pulse"}, int'(ack), 0);
    checkOutput({tag, " hold quotient"}, int'(quotient), refQuot(dd, dv));
  endtask

  initial begin
    int cyc;
    int busyCount;
    int ackSeen;
    int ack1;
    int ack2;
    int dd;
    int dv;
    logic [N-1:0] qs;
    logic [N-1:0] rs;

    rst_n    = 1'b0;
    req      = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset remainder", int'(remainder), 0);
    checkOutput("reset ack", int'(ack), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed operands");
    runOp("100/7", 100, 7);
    runOp("255/1", 255, 1);
    runOp("5/9", 5, 9);
    runOp("255/255", 255, 255);
    runOp("37/0", 37, 0);

    $display("[TB] operand change during compute");
    applyStimulus(100, 7);
    busyCount = 0;
    qs = '0;
    rs = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
      busyCount++;
      dividend = 8'd3;
      divisor  = 8'd1;
      if (ack) begin
        qs  = quotient;
        rs  = remainder;
        req = 1'b0;
      end else begin
        req = ~req;
      end
    end
    req = 1'b0;
    checkOutput("midchange busy cycles", busyCount, N + 1);
    checkOutput("midchange quotient", int'(qs), 14);
    checkOutput("midchange remainder", int'(rs), 2);
    checkOutput("midchange hold", int'(quotient), 14);

    $display("[TB] back-to-back");
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd3;
    req      = 1'b1;
    ack1 = -1;
    ack2 = -1;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      if (ack && ack1 < 0) begin
        ack1 = i;
        checkOutput("b2b first quotient", int'(quotient), 66);
        checkOutput("b2b first remainder", int'(remainder), 2);
        dividend = 8'd50;
        divisor  = 8'd6;
      end else if (ack && ack1 >= 0) begin
        ack2 = i;
        checkOutput("b2b second quotient", int'(quotient), 8);
        checkOutput("b2b second remainder", int'(remainder), 2);
        req = 1'b0;
        break;
      end
    end
    req = 1'b0;
    checkOutput("b2b first latency", ack1, N + 1);
    checkOutput("b2b ack spacing", ack2 - ack1, N + 2);
    @(negedge clk);
    checkOutput("b2b idle busy", int'(busy), 0);

    $display("[TB] reset mid-operation");
    applyStimulus(200, 3);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset quotient", int'(quotient), 0);
    checkOutput("midreset remainder", int'(remainder), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset ack", int'(ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ackSeen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack || busy) ackSeen++;
    end
    checkOutput("midreset no ack", ackSeen, 0);
    runOp("9/4", 9, 4);

    $display("[TB] random operands");
    for (int i = 0; i < 20; i++) begin
      dd = int'($urandom_range(255, 0));
      dv = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(255, 1));
      applyStimulus(dd, dv);
      waitAck(cyc);
      checkOutput("rand latency", cyc, (dv == 0) ? 1 : N + 1);
      checkOutput("rand quotient", int'(quotient), refQuot(dd, dv));
      checkOutput("rand remainder", int'(remainder), refRem(dd, dv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
